// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter letting NM bus masters share one memory-mapped slave port.
// Optional BUS_ARB_TIMEOUT_EN aborts a BUSY access after TIMEOUT cycles and pulses bus_err.
module bus_arbiter_rr #(
   parameter int NM      = 3,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   localparam int GW     = $clog2(NM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NM*AW-1:0] m_addr,
   input  logic [NM*DW-1:0] m_wdata,
   input  logic [NM*2-1:0]  m_rw,
   output logic [DW-1:0]    m_rdata,
   output logic [NM-1:0]    m_stall,
   output logic [AW-1:0]    s_addr,
   output logic [DW-1:0]    s_wdata,
   output logic [1:0]       s_rw,
   input  logic [DW-1:0]    s_rdata,
   input  logic             s_ack,
   output logic [GW-1:0]    grant_id,
   output logic             bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] RW_IDLE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   if (NM < 2 || NM > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
      $error("bus_arbiter_rr: NM or TIMEOUT out of range");
   end

   state_t        state, state_d;
   logic [GW-1:0] ptr, ptr_d;
   logic [GW-1:0] grant_id_d;
   logic [AW-1:0] s_addr_d;
   logic [DW-1:0] s_wdata_d;
   logic [1:0]    s_rw_d;
   logic [DW-1:0] m_rdata_d;

   logic [NM-1:0] req;
   logic          pick_valid;
   int            pick_idx;
   int            cand;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] tmo_cnt, tmo_cnt_d;
   logic        bus_err_q, bus_err_d;

   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   // Encoding 11 is deliberately not a request.
   always_comb begin
      for (int i = 0; i < NM; i++) begin
         req[i] = (m_rw[2*i +: 2] == RW_READ) || (m_rw[2*i +: 2] == RW_WRITE);
      end
   end

   // The only combinational path to the masters: release happens in the RESP cycle.
   always_comb begin
      for (int i = 0; i < NM; i++) begin
         m_stall[i] = req[i] && !((state == ST_RESP) && (grant_id == GW'(i)));
      end
   end

   // Scan downward so the requester closest above ptr is the last one written.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 0;
      cand       = 0;
      for (int k = NM - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= NM) begin
            cand = cand - NM;
         end
         if (req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves one unassigned and infers a latch.
      state_d    = state;
      ptr_d      = ptr;
      grant_id_d = grant_id;
      s_addr_d   = s_addr;
      s_wdata_d  = s_wdata;
      s_rw_d     = s_rw;
      m_rdata_d  = m_rdata;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt;
      bus_err_d  = 1'b0;
`endif

      case (state)
         ST_IDLE: begin
            s_rw_d = RW_IDLE;
            if (pick_valid) begin
               grant_id_d = GW'(pick_idx);
               s_addr_d   = m_addr[pick_idx*AW +: AW];
               s_wdata_d  = m_wdata[pick_idx*DW +: DW];
               s_rw_d     = m_rw[2*pick_idx +: 2];
               state_d    = ST_BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
               tmo_cnt_d  = '0;
`endif
            end
         end

         ST_BUSY: begin
            // An ack arriving together with the timeout is a normal completion.
            if (s_ack) begin
               if (s_rw == RW_READ) begin
                  m_rdata_d = s_rdata;
               end
               s_rw_d  = RW_IDLE;
               state_d = ST_RESP;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               m_rdata_d = '0;
               s_rw_d    = RW_IDLE;
               bus_err_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               tmo_cnt_d = tmo_cnt + 16'd1;
            end
`endif
         end

         ST_RESP: begin
            // ptr moves past the finished master even if it withdrew mid-access.
            ptr_d   = (grant_id == GW'(NM - 1)) ? '0 : grant_id + 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         grant_id  <= '0;
         s_addr    <= '0;
         s_wdata   <= '0;
         s_rw      <= RW_IDLE;
         m_rdata   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
         tmo_cnt   <= '0;
         bus_err_q <= 1'b0;
`endif
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         state     <= state_d;
         ptr       <= ptr_d;
         grant_id  <= grant_id_d;
         s_addr    <= s_addr_d;
         s_wdata   <= s_wdata_d;
         s_rw      <= s_rw_d;
         m_rdata   <= m_rdata_d;
`ifdef BUS_ARB_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_d;
         bus_err_q <= bus_err_d;
`endif
      end
   end

endmodule
